// File: rtl/clock_pkg.sv
// Shared constants and helpers for the BCD clock/timer.
// Binary load/alarm values are clamped to range and converted to two BCD digits.
package clock_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [5:0] SEC_MAX     = 6'd59;
    localparam logic [5:0] MIN_MAX     = 6'd59;
    localparam logic [5:0] HR_MAX      = 6'd23;
    localparam logic [3:0] SEP_DEFAULT = 4'hE;

    function automatic logic [2*DIGIT_W-1:0] bin_to_bcd_clamp(input logic [5:0] v,
                                                            input logic [5:0] lim);
        logic [5:0] c;
        logic [5:0] tens;
        logic [5:0] ones;
        c    = (v > lim) ? lim : v;
        tens = c / 6'd10;
        ones = c - tens * 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX_BCD) with load, increment and decrement.
// carry/borrow flag the wrap so counters can be chained within one cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [2*DIGIT_W-1:0] MAX_BCD  = 8'h59,
    parameter logic [2*DIGIT_W-1:0] INIT_BCD = 8'h00
) (
    input  logic                   clk_50mhz,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   load,
    input  logic [2*DIGIT_W-1:0]   load_val,
    output logic [2*DIGIT_W-1:0]   val,
    output logic [2*DIGIT_W-1:0]   nxt,
    output logic                   carry,
    output logic                   borrow
);

    logic [2*DIGIT_W-1:0] val_q;

    assign val = val_q;

    always_comb begin
        nxt    = val_q;
        carry  = 1'b0;
        borrow = 1'b0;
        if (load) begin
            nxt = load_val;
        end else if (inc) begin
            if (val_q == MAX_BCD) begin
                nxt   = '0;
                carry = 1'b1;
            end else if (val_q[DIGIT_W-1:0] == 4'd9) begin
                nxt = {val_q[2*DIGIT_W-1:DIGIT_W] + 4'd1, 4'd0};
            end else begin
                nxt = {val_q[2*DIGIT_W-1:DIGIT_W], val_q[DIGIT_W-1:0] + 4'd1};
            end
        end else if (dec) begin
            if (val_q == '0) begin
                nxt    = MAX_BCD;
                borrow = 1'b1;
            end else if (val_q[DIGIT_W-1:0] == 4'd0) begin
                nxt = {val_q[2*DIGIT_W-1:DIGIT_W] - 4'd1, 4'd9};
            end else begin
                nxt = {val_q[2*DIGIT_W-1:DIGIT_W], val_q[DIGIT_W-1:0] - 4'd1};
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) val_q <= INIT_BCD;
        else     val_q <= nxt;
    end

endmodule

// File: rtl/clock_timer_bcd.sv
// Real-time clock / countdown timer held as BCD digits, with run/pause button,
// load, up/down counting, countdown expiry and alarm; drives a packed HH-MM-SS word.
module clock_timer_bcd
    import clock_pkg::*;
#(
    parameter int         CLK_HZ   = 50000000,
    parameter int         INIT_HR  = 15,
    parameter int         INIT_MIN = 0,
    parameter int         INIT_SEC = 0,
    parameter logic [3:0] SEP_CODE = SEP_DEFAULT
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        pause_btn,
    input  logic        mode_down,
    input  logic        load,
    input  logic [4:0]  load_hr,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_sec,
    input  logic        alarm_en,
    input  logic [4:0]  alarm_hr,
    input  logic [5:0]  alarm_min,
    output logic [31:0] out,
    output logic        running,
    output logic        sec_pulse,
    output logic        alarm,
    output logic        expired
);

    localparam int            PW       = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);

    localparam logic [7:0] INIT_HR_BCD  = bin_to_bcd_clamp(6'(INIT_HR), HR_MAX);
    localparam logic [7:0] INIT_MIN_BCD = bin_to_bcd_clamp(6'(INIT_MIN), MIN_MAX);
    localparam logic [7:0] INIT_SEC_BCD = bin_to_bcd_clamp(6'(INIT_SEC), SEC_MAX);

    logic [PW-1:0] prescaler;
    logic          sync1, sync2, sync_prev;
    logic          pause_edge, tick, step, up_step, dn_step;
    logic          next_zero, alarm_hit;
    logic [7:0]    sec_val, min_val, hr_val;
    logic [7:0]    sec_nxt, min_nxt, hr_nxt;
    logic          sec_carry, sec_borrow, min_carry, min_borrow, hr_carry, hr_borrow;
    logic          hr_unused;
    logic [7:0]    ld_hr_bcd, ld_min_bcd, ld_sec_bcd, al_hr_bcd, al_min_bcd;

    assign pause_edge = sync2 & ~sync_prev;
    assign tick       = running & (prescaler == PRE_LAST);
    // A load on the tick cycle swallows that tick entirely.
    assign step       = tick & ~load;
    assign up_step    = step & ~mode_down;
    assign dn_step    = step & mode_down;

    assign ld_hr_bcd  = bin_to_bcd_clamp({1'b0, load_hr}, HR_MAX);
    assign ld_min_bcd = bin_to_bcd_clamp(load_min, MIN_MAX);
    assign ld_sec_bcd = bin_to_bcd_clamp(load_sec, SEC_MAX);
    assign al_hr_bcd  = bin_to_bcd_clamp({1'b0, alarm_hr}, HR_MAX);
    assign al_min_bcd = bin_to_bcd_clamp(alarm_min, MIN_MAX);

    bcd_mod_counter #(.MAX_BCD(8'h59), .INIT_BCD(INIT_SEC_BCD)) u_sec (
        .clk_50mhz(clk_50mhz), .rst(rst), .inc(up_step), .dec(dn_step), .load(load),
        .load_val(ld_sec_bcd), .val(sec_val), .nxt(sec_nxt),
        .carry(sec_carry), .borrow(sec_borrow)
    );

    bcd_mod_counter #(.MAX_BCD(8'h59), .INIT_BCD(INIT_MIN_BCD)) u_min (
        .clk_50mhz(clk_50mhz), .rst(rst), .inc(sec_carry), .dec(sec_borrow), .load(load),
        .load_val(ld_min_bcd), .val(min_val), .nxt(min_nxt),
        .carry(min_carry), .borrow(min_borrow)
    );

    bcd_mod_counter #(.MAX_BCD(8'h23), .INIT_BCD(INIT_HR_BCD)) u_hr (
        .clk_50mhz(clk_50mhz), .rst(rst), .inc(min_carry), .dec(min_borrow), .load(load),
        .load_val(ld_hr_bcd), .val(hr_val), .nxt(hr_nxt),
        .carry(hr_carry), .borrow(hr_borrow)
    );

    // Hour wrap needs no further propagation.
    assign hr_unused = hr_carry | hr_borrow;

    assign next_zero = ({hr_nxt, min_nxt, sec_nxt} == 24'h000000);
    assign alarm_hit = ({hr_nxt, min_nxt, sec_nxt} == {al_hr_bcd, al_min_bcd, 8'h00});

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            prescaler <= '0;
            running   <= 1'b0;
            sec_pulse <= 1'b0;
            alarm     <= 1'b0;
            expired   <= 1'b0;
        end else begin
            sync1     <= pause_btn;
            sync2     <= sync1;
            sync_prev <= sync2;
            sec_pulse <= step;

            if (load)         prescaler <= '0;
            else if (running) prescaler <= tick ? '0 : prescaler + 1'b1;

            if (dn_step && next_zero) running <= 1'b0;
            else if (pause_edge)      running <= ~running;

            if (load)                      expired <= 1'b0;
            else if (dn_step && next_zero) expired <= 1'b1;

            if (!alarm_en)              alarm <= 1'b0;
            else if (step && alarm_hit) alarm <= 1'b1;
        end
    end

    assign out = {hr_val, SEP_CODE, min_val, SEP_CODE, sec_val};

endmodule

// File: tb/tb_clock_timer_bcd.sv
// Self-checking bench for clock_timer_bcd: directed scenarios plus random stimulus,
// compared each cycle against a seconds-of-day reference model.
module tb_clock_timer_bcd;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1;
    logic        pause_btn = 1'b0;
    logic        mode_down = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  load_hr = '0;
    logic [5:0]  load_min = '0;
    logic [5:0]  load_sec = '0;
    logic        alarm_en = 1'b0;
    logic [4:0]  alarm_hr = '0;
    logic [5:0]  alarm_min = '0;
    logic [31:0] out;
    logic        running, sec_pulse, alarm, expired;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_t, m_pre;
    bit m_run, m_pulse, m_alarm, m_exp, m_s1, m_s2, m_s3;

    clock_timer_bcd #(.CLK_HZ(CLK_HZ)) dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .pause_btn(pause_btn), .mode_down(mode_down),
        .load(load), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
        .alarm_en(alarm_en), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .out(out), .running(running), .sec_pulse(sec_pulse), .alarm(alarm),
        .expired(expired)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    function automatic int clampv(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [31:0] pack_time(int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'hE, 4'(m / 10), 4'(m % 10), 4'hE,
                4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_edge();
        bit pedge, tick, nrun;
        if (rst) begin
            m_t = 15 * 3600; m_pre = 0; m_run = 0; m_pulse = 0;
            m_alarm = 0; m_exp = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0;
        end else begin
            pedge   = m_s2 && !m_s3;
            tick    = m_run && (m_pre == CLK_HZ - 1);
            nrun    = m_run ^ pedge;
            m_pulse = tick && !load;
            if (load) begin
                m_t   = clampv(int'(load_hr), 23) * 3600 + clampv(int'(load_min), 59) * 60
                        + clampv(int'(load_sec), 59);
                m_pre = 0;
                m_exp = 0;
            end else if (tick) begin
                m_pre = 0;
                m_t   = mode_down ? (m_t + DAY - 1) % DAY : (m_t + 1) % DAY;
                if (mode_down && m_t == 0) begin
                    m_exp = 1;
                    nrun  = 0;
                end
                if (alarm_en && m_t == clampv(int'(alarm_hr), 23) * 3600
                                       + clampv(int'(alarm_min), 59) * 60)
                    m_alarm = 1;
            end else if (m_run) begin
                m_pre++;
            end
            if (!alarm_en) m_alarm = 0;
            m_run = nrun;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = pause_btn;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("out", out, pack_time(m_t));
        check("running", 32'(running), 32'(m_run));
        check("sec_pulse", 32'(sec_pulse), 32'(m_pulse));
        check("alarm", 32'(alarm), 32'(m_alarm));
        check("expired", 32'(expired), 32'(m_exp));
        check("prescaler", 32'(dut.prescaler), 32'(m_pre));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk_50mhz);
        #1;
        check_model();
    endtask

    task automatic do_load(int h, int m, int s);
        load_hr = 5'(h); load_min = 6'(m); load_sec = 6'(s);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic press();
        pause_btn = 1'b1; cyc();
        pause_btn = 1'b0; cyc(); cyc();
    endtask

    initial begin
        int np;
        // reset
        rst = 1'b1; cyc(); cyc();
        rst = 1'b0;
        check("rst_out", out, 32'h15E00E00);
        check("rst_run", 32'(running), 32'd0);

        // 1: run for 10 cycles between two button edges
        pause_btn = 1'b1; cyc(); cyc(); cyc();
        check("t1_run_on", 32'(running), 32'd1);
        pause_btn = 1'b0;
        repeat (7) cyc();
        pause_btn = 1'b1; cyc(); cyc(); cyc();
        pause_btn = 1'b0;
        check("t1_run_off", 32'(running), 32'd0);
        check("t1_out", out, 32'h15E00E02);
        check("t1_pre", 32'(dut.prescaler), 32'd2);

        // 2: up-mode day wrap
        do_load(23, 59, 58);
        press();
        check("t2_run", 32'(running), 32'd1);
        np = 0;
        repeat (8) begin cyc(); if (sec_pulse) np++; end
        check("t2_out", out, 32'h00E00E00);
        check("t2_pulses", 32'(np), 32'd2);

        // 3: down-mode expiry
        mode_down = 1'b1;
        do_load(0, 0, 2);
        repeat (8) cyc();
        check("t3_out", out, 32'h00E00E00);
        check("t3_expired", 32'(expired), 32'd1);
        check("t3_run", 32'(running), 32'd0);
        repeat (20) cyc();
        check("t3_hold", out, 32'h00E00E00);

        // 4: clamp and load-over-tick priority
        mode_down = 1'b0;
        press();
        repeat (3) cyc();
        check("t4_pre_last", 32'(dut.prescaler), 32'd3);
        do_load(31, 63, 60);
        check("t4_out", out, 32'h23E59E59);
        check("t4_pulse", 32'(sec_pulse), 32'd0);
        check("t4_pre0", 32'(dut.prescaler), 32'd0);
        check("t4_exp_clr", 32'(expired), 32'd0);
        cyc();
        check("t4_pre1", 32'(dut.prescaler), 32'd1);

        // 5: alarm
        alarm_en = 1'b1; alarm_hr = 5'd7; alarm_min = 6'd30;
        do_load(7, 29, 59);
        check("t5_no_alarm", 32'(alarm), 32'd0);
        repeat (4) cyc();
        check("t5_out", out, 32'h07E30E00);
        check("t5_alarm", 32'(alarm), 32'd1);
        repeat (12) cyc();
        check("t5_sticky", 32'(alarm), 32'd1);
        alarm_en = 1'b0; cyc();
        check("t5_clear", 32'(alarm), 32'd0);

        // 6: reset with alarm and expired both set
        alarm_en = 1'b1; alarm_hr = 5'd0; alarm_min = 6'd0; mode_down = 1'b1;
        do_load(0, 0, 2);
        repeat (8) cyc();
        check("t6_alarm_set", 32'(alarm), 32'd1);
        check("t6_exp_set", 32'(expired), 32'd1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        check("t6_out", out, 32'h15E00E00);
        check("t6_flags", {29'd0, running, alarm, expired}, 32'd0);

        // random phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 31) == 0) mode_down = ~mode_down;
            if ($urandom_range(0, 63) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if ($urandom_range(0, 23) == 0) begin
                load_hr  = 5'($urandom_range(0, 31));
                load_min = 6'($urandom_range(0, 63));
                load_sec = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) begin
                    alarm_hr  = load_hr;
                    alarm_min = (load_min < 6'd59) ? load_min + 6'd1 : 6'd0;
                    load_sec  = 6'($urandom_range(56, 59));
                end
                load = 1'b1;
            end
            cyc();
            load = 1'b0;
            rst  = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
